// File: rtl/week_counter_if.sv
// Signal bundle between the upstream 7-state counter, the week_counter and its consumer.
// master drives the upstream state and enable; slave is the week_counter side.
interface week_counter_if;
  logic       y1;
  logic       y2;
  logic       y3;
  logic       en;
  logic [3:0] wk_ones;
  logic [3:0] wk_tens;
  logic       week_tick;
  logic       carry;
  logic       err;

  modport master (
    output y1, y2, y3, en,
    input  wk_ones, wk_tens, week_tick, carry, err
  );

  modport slave (
    input  y1, y2, y3, en,
    output wk_ones, wk_tens, week_tick, carry, err
  );
endinterface

// File: rtl/week_counter.sv
// Counts 6->0 wraps of an upstream 7-state counter into a BCD week count modulo MAX_WEEKS.
// Define WEEK_COUNTER_SEQCHK_EN to build the sticky illegal-sequence checker.
module week_counter #(
  parameter int unsigned MAX_WEEKS = 52
) (
  input logic          Cp,
  input logic          _R,
  week_counter_if.slave bus
);

  localparam logic [3:0] LastTens = 4'((MAX_WEEKS - 1) / 10);
  localparam logic [3:0] LastOnes = 4'((MAX_WEEKS - 1) % 10);

`ifdef WEEK_COUNTER_SEQCHK_EN
  typedef enum logic [1:0] {StInit, StRun, StErr} state_e;
`else
  typedef enum logic [0:0] {StInit, StRun} state_e;
`endif

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       tick_q, tick_d;
  logic       carry_q, carry_d;
  logic [2:0] c;
  logic       hit;

  assign c   = {bus.y3, bus.y2, bus.y1};
  assign hit = (prev_q == 3'd6) && (c == 3'd0) && bus.en;

`ifdef WEEK_COUNTER_SEQCHK_EN
  logic       err_q, err_d;
  logic [2:0] seq_next;
  logic       seq_ok;

  assign seq_next = (prev_q == 3'd6) ? 3'd0 : prev_q + 3'd1;
  // c==0 is also accepted: the upstream counter may have been reset.
  assign seq_ok   = (c == seq_next) || (c == 3'd0);
`endif

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
`ifdef WEEK_COUNTER_SEQCHK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StInit: begin
        prev_d  = c;
        state_d = StRun;
      end
      StRun: begin
        prev_d = c;
`ifdef WEEK_COUNTER_SEQCHK_EN
        if (!seq_ok) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else
`endif
        if (hit) begin
          tick_d = 1'b1;
          if (tens_q == LastTens && ones_q == LastOnes) begin
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            carry_d = 1'b1;
          end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end
      end
`ifdef WEEK_COUNTER_SEQCHK_EN
      StErr: begin
        // Frozen until reset; defaults already hold everything.
      end
`endif
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge Cp) begin
    if (!_R) begin
      state_q <= StInit;
      prev_q  <= 3'd0;
      ones_q  <= 4'd0;
      tens_q  <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
`ifdef WEEK_COUNTER_SEQCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
`ifdef WEEK_COUNTER_SEQCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.wk_ones   = ones_q;
  assign bus.wk_tens   = tens_q;
  assign bus.week_tick = tick_q;
  assign bus.carry     = carry_q;
`ifdef WEEK_COUNTER_SEQCHK_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_week_counter.sv
// Self-checking bench for week_counter: directed scenarios plus randomized upstream sequences
// compared against an integer week-count model.
module tb_week_counter;

  localparam int unsigned MaxWeeks = 52;

  logic Cp;
  logic _R;
  week_counter_if bus ();

  week_counter #(.MAX_WEEKS(MaxWeeks)) dut (
    .Cp  (Cp),
    ._R  (_R),
    .bus (bus)
  );

  initial Cp = 1'b0;
  always #5 Cp = ~Cp;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_count;
  int m_prev;
  bit m_started;
  bit m_err;
  bit m_tick;
  bit m_carry;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int c, input bit e, input bit r);
    m_tick  = 0;
    m_carry = 0;
    if (!r) begin
      m_count = 0; m_prev = 0; m_started = 0; m_err = 0;
    end else if (!m_started) begin
      m_prev = c; m_started = 1;
    end else if (!m_err) begin
`ifdef WEEK_COUNTER_SEQCHK_EN
      if (c != (m_prev + 1) % 7 && c != 0) m_err = 1;
      else
`endif
      if (m_prev == 6 && c == 0 && e) begin
        m_tick  = 1;
        m_count = m_count + 1;
        if (m_count == int'(MaxWeeks)) begin
          m_count = 0;
          m_carry = 1;
        end
      end
      m_prev = c;
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare 1 time unit later.
  task automatic step(input logic [2:0] c, input logic e, input logic r);
    @(negedge Cp);
    {bus.y3, bus.y2, bus.y1} = c;
    bus.en = e;
    _R     = r;
    @(posedge Cp);
    model_step(int'(c), e, r);
    #1;
    check("wk_ones",   8'(bus.wk_ones),   8'(m_count % 10));
    check("wk_tens",   8'(bus.wk_tens),   8'(m_count / 10));
    check("week_tick", 8'(bus.week_tick), 8'(m_tick));
    check("carry",     8'(bus.carry),     8'(m_carry));
    check("err",       8'(bus.err),       8'(m_err));
  endtask

  task automatic do_reset();
    step(3'd3, 1'b1, 1'b0);
    step(3'd3, 1'b1, 1'b0);
  endtask

  // Feeds 1..6,0 n times, assuming the last value fed was 0.
  task automatic run_weeks(input int n);
    for (int w = 0; w < n; w++)
      for (int v = 1; v <= 7; v++) step(3'(v % 7), 1'b1, 1'b1);
  endtask

  initial begin
    logic [2:0] cur;
    _R = 1'b0;
    bus.en = 1'b1;
    {bus.y3, bus.y2, bus.y1} = 3'd3;
    model_step(0, 1'b1, 1'b0);

    // Reset, then first post-reset 0 must not tick even after a 6.
    step(3'd6, 1'b1, 1'b1);
    do_reset();
    step(3'd0, 1'b1, 1'b1);
    check("first_zero_no_tick", 8'(bus.week_tick), 8'd0);

    // Single week, then BCD rollover at 10.
    run_weeks(1);
    check("single_week_ones", 8'(bus.wk_ones), 8'd1);
    run_weeks(9);
    check("rollover_tens", 8'(bus.wk_tens), 8'd1);
    check("rollover_ones", 8'(bus.wk_ones), 8'd0);

    // Modulus wrap at 52.
    do_reset();
    step(3'd0, 1'b1, 1'b1);
    run_weeks(51);
    check("wk51_tens", 8'(bus.wk_tens), 8'd5);
    check("wk51_ones", 8'(bus.wk_ones), 8'd1);
    run_weeks(1);
    check("wrap_carry", 8'(bus.carry), 8'd1);
    check("wrap_tick",  8'(bus.week_tick), 8'd1);
    check("wrap_ones",  8'(bus.wk_ones), 8'd0);
    step(3'd1, 1'b1, 1'b1);
    check("carry_one_cycle", 8'(bus.carry), 8'd0);

    // Enable gating loses the week.
    do_reset();
    step(3'd0, 1'b1, 1'b1);
    run_weeks(3);
    for (int v = 1; v <= 6; v++) step(3'(v), 1'b1, 1'b1);
    step(3'd0, 1'b0, 1'b1);
    check("gated_no_tick", 8'(bus.week_tick), 8'd0);
    check("gated_count",   8'(bus.wk_ones), 8'd3);
    run_weeks(1);
    check("ungated_count", 8'(bus.wk_ones), 8'd4);

    // Illegal code 7 after 4, then 5,6,0.
    for (int v = 1; v <= 4; v++) step(3'(v), 1'b1, 1'b1);
    step(3'd7, 1'b1, 1'b1);
    step(3'd5, 1'b1, 1'b1);
    step(3'd6, 1'b1, 1'b1);
    step(3'd0, 1'b1, 1'b1);
    do_reset();
    check("err_cleared", 8'(bus.err), 8'd0);

    // Randomized: mostly healthy counting, random enable, occasional glitches and resets.
    cur = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      int unsigned roll;
      roll = $urandom_range(0, 99);
      if (roll < 2) begin
        step(cur, 1'b1, 1'b0);
        cur = 3'd0;
      end else begin
        if (roll < 5) cur = 3'($urandom_range(0, 7));
        else if (roll < 7) cur = 3'd0;
        else cur = (cur >= 3'd6) ? 3'd0 : cur + 3'd1;
        step(cur, ($urandom_range(0, 9) != 0), 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/week_counter.md
# week_counter

Downstream stage of the synchronous 7-state counter: it samples the counter's 3-bit state {y3,y2,y1} each clock, detects the 6→0 wrap (one "week" completed), and accumulates completed weeks in a 2-digit BCD counter that wraps at a configurable limit. It produces a one-cycle tick per week and a one-cycle carry on wrap for further cascading. An optional checker flags illegal upstream sequences.

## Interface
- MAX_WEEKS, default 52: week-count modulus; the count runs 00..MAX_WEEKS-1 in BCD; legal range 2..99.
- Cp  in  1  clock; all state updates on the rising edge.
- _R  in  1  reset, synchronous, active-low; sampled on the rising edge of Cp.
- y1  in  1  upstream count bit 0 (LSB).
- y2  in  1  upstream count bit 1.
- y3  in  1  upstream count bit 2 (MSB); {y3,y2,y1} is 0..6 in normal operation.
- en  in  1  count enable; when low, week ticks are suppressed.
- wk_ones  out  4  BCD ones digit of completed weeks.
- wk_tens  out  4  BCD tens digit of completed weeks.
- week_tick  out  1  registered one-cycle pulse per detected 6→0 wrap.
- carry  out  1  registered one-cycle pulse when the week count wraps MAX_WEEKS-1 → 00.
- err  out  1  sticky illegal-sequence flag; constant 0 when the checker is compiled out.

## Operation
- Internal state: prev (3 b, last sampled {y3,y2,y1}), FSM state, BCD digits.
- FSM states:
  - INIT: after reset. The first edge with _R=1 loads prev, moves to RUN, and produces no tick.
  - RUN: normal counting.
  - ERR: checker build only.
- RUN, each edge: c={y3,y2,y1}; hit = (prev==6) && (c==0) && en; prev←c in all cases, including when en=0.
- On hit:
  - week_tick=1.
  - BCD increment: ones 9→0 with tens+1.
  - If count==MAX_WEEKS-1: count←00 and carry=1 in the same cycle as week_tick.
- week_tick and carry are 0 on every edge without hit.
- en=0 during a 6→0 wrap loses that week; it is not deferred.
- Reset (_R=0 at an edge) overrides all events: wk_tens=0, wk_ones=0, week_tick=0, carry=0, err=0, prev=0, state=INIT.
- A reset mid-run drops any pending wrap. A 0 sampled on the first post-reset edge is never a tick, even if 6 was sampled before the reset.
- BCD digits never hold values >9. MAX_WEEKS is compared as a BCD pair: tens = MAX_WEEKS-1 div 10, ones = MAX_WEEKS-1 mod 10.

## Timing
- Latency: an input transition 6→0 sampled at edge k (prev=6 from edge k-1, c=0 at edge k) gives week_tick=1, carry (if wrapping), and updated digits visible after edge k. That is one cycle after the upstream counter presents 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Upstream runs on the same Cp, so a healthy input advances by exactly one state per edge. A full week is 7 edges, with ticks spaced 7 cycles apart.
- week_tick and carry are high for exactly one cycle per event. They are never stretched, and the same event never asserts them twice.

## Configuration
- Macro WEEK_COUNTER_SEQCHK_EN.
- Defined: in RUN, each edge checks c. Legal values are c==(prev+1) mod 7, or c==0 (upstream reset).
  - c==7 or any other value → state ERR, err=1 after that edge, no tick on that edge.
  - ERR freezes the digits, forces week_tick=carry=0, and ignores all inputs until _R=0.
  - The check runs even when en=0.
- Undefined: no checker and no ERR state. err is tied to 0. Code 7 or jumps are treated as ordinary non-6/non-0 values: only prev==6 && c==0 ticks.

## Test plan
- Reset: _R=0 for 2 edges with {y3,y2,y1}=3 → wk_tens=0, wk_ones=0, week_tick=0, carry=0, err=0. On release, the first sample of 0 gives no tick.
- Single week: after reset feed 0,1,…,6,0 → week_tick=1 for exactly one cycle, after the edge sampling the final 0; wk_ones=1, wk_tens=0.
- BCD rollover: 10 full weeks → wk_tens=1, wk_ones=0, carry=0 throughout.
- Modulus wrap: MAX_WEEKS=52, 52 weeks → after week 51 the outputs read 5/1. On week 52 the outputs read 0/0, with carry=1 and week_tick=1 in the same single cycle.
- Enable gating: en=0 across one 6→0 with count 3 → no week_tick, count stays 3. With en=1 on the next wrap, count=4.
- Checker:
  - With WEEK_COUNTER_SEQCHK_EN, inject 7 after 4 → err=1 after that edge. A subsequent 5,6,0 gives no tick and the count is unchanged. err clears only after _R=0.
  - Without the macro, the same stimulus leaves err=0, and the later 6→0 ticks normally.
